canvas_painter: RTL and testbench

- Converts PS/2 mouse state into writes to the two 28x28 1-bit canvas/input block RAMs. These are the canvas RAM the VGA path displays and the input RAM the neural network reads.
- Sits between the mouse controller and the RAM write ports (wea/addra/dina).
- Stamps a 3x3 brush while the left button is held, clears the whole image on a right click, and zeroes the image after reset.

---
 rtl/canvas_pkg.sv | 29 ++
 rtl/canvas_painter_screen_to_cell.sv | 36 +++
 rtl/canvas_painter.sv | 167 ++++++++++++++++
 tb/tb_canvas_painter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// Shared canvas geometry, state encoding and cell addressing.
// Also used by the display address generator so both stay aligned.
package canvas_pkg;

    localparam int GRID             = 28;
    localparam int GRID_CELLS       = GRID * GRID;
    localparam int ADDR_W           = 10;
    localparam int CANVAS_X0        = 208;
    localparam int CANVAS_Y0        = 128;
    localparam int CANVAS_CELL_LOG2 = 3;
    localparam int STAMP_LAST       = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STAMP,
        S_CLEAR
    } state_t;

    // row*28+col without a multiplier
    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [4:0] row,
        input logic [4:0] col
    );
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 4) + (r << 3) + (r << 2) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/canvas_painter_screen_to_cell.sv
// Maps a screen pointer position onto a canvas cell.
// Purely combinational; row/col/addr are meaningful only when in_canvas_o is high.
module screen_to_cell
    import canvas_pkg::*;
#(
    parameter int X0        = CANVAS_X0,
    parameter int Y0        = CANVAS_Y0,
    parameter int CELL_LOG2 = CANVAS_CELL_LOG2
) (
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    output logic              in_canvas_o,
    output logic [4:0]        row_o,
    output logic [4:0]        col_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int SPAN = GRID << CELL_LOG2;

    logic [10:0] dx;
    logic [10:0] dy;
    logic        x_in;
    logic        y_in;

    assign dx = {1'b0, x_i} - 11'(X0);
    assign dy = {1'b0, y_i} - 11'(Y0);

    assign x_in = ({1'b0, x_i} >= 11'(X0)) && (dx < 11'(SPAN));
    assign y_in = ({1'b0, y_i} >= 11'(Y0)) && (dy < 11'(SPAN));

    assign in_canvas_o = x_in && y_in;
    assign col_o       = dx[CELL_LOG2 +: 5];
    assign row_o       = dy[CELL_LOG2 +: 5];
    assign addr_o      = cell_addr(row_o, col_o);

endmodule

// File: rtl/canvas_painter.sv
// Turns mouse state into canvas RAM writes: 3x3 brush stamps on left drag,
// full-image clear on right click and after reset.
module canvas_painter
    import canvas_pkg::*;
#(
    parameter int X0        = CANVAS_X0,
    parameter int Y0        = CANVAS_Y0,
    parameter int CELL_LOG2 = CANVAS_CELL_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mouse_left,
    input  logic              mouse_right,
    input  logic [9:0]        mouse_x,
    input  logic [9:0]        mouse_y,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic              write_data,
    output logic              busy,
    output logic              canvas_changed
);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [4:0]        last_row_q;
    logic [4:0]        last_col_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic              last_valid_q;
    logic              armed_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic              data_q;
    logic              busy_q;
    logic              done_q;
    logic              changed_q;

    logic              in_canvas;
    logic [4:0]        row;
    logic [4:0]        col;
    logic [ADDR_W-1:0] addr;

    screen_to_cell #(
        .X0       (X0),
        .Y0       (Y0),
        .CELL_LOG2(CELL_LOG2)
    ) u_map (
        .x_i        (mouse_x),
        .y_i        (mouse_y),
        .in_canvas_o(in_canvas),
        .row_o      (row),
        .col_o      (col),
        .addr_o     (addr)
    );

    logic              on_canvas;
    logic              new_cell;
    logic              trig_clear;
    logic              trig_stamp;

    assign on_canvas  = mouse_left && in_canvas;
    assign new_cell   = !last_valid_q || (row != last_row_q)
                        || (col != last_col_q);
    assign trig_clear = mouse_right && armed_q;
    assign trig_stamp = on_canvas && new_cell;

    // Brush offset for beat k: kr = k/3, kc = k%3, centre at (1,1)
    logic [3:0]        k;
    logic [1:0]        kr;
    logic [3:0]        kc_w;
    logic [1:0]        kc;
    logic [5:0]        nr;
    logic [5:0]        nc;
    logic              hit;
    logic [ADDR_W-1:0] naddr;

    assign k    = cnt_q[3:0];
    assign kr   = (k >= 4'd6) ? 2'd2 : (k >= 4'd3) ? 2'd1 : 2'd0;
    assign kc_w = k - 4'(kr) * 4'd3;
    assign kc   = kc_w[1:0];
    assign nr   = {1'b0, last_row_q} + {4'b0, kr} - 6'd1;
    assign nc   = {1'b0, last_col_q} + {4'b0, kc} - 6'd1;
    assign hit  = (nr < 6'(GRID)) && (nc < 6'(GRID));

    // Offset from the centre; wraps harmlessly when clipped
    assign naddr = last_addr_q + ADDR_W'(kr) * ADDR_W'(GRID)
                   + ADDR_W'(kc) - ADDR_W'(GRID + 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            last_row_q   <= '0;
            last_col_q   <= '0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            armed_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            data_q    <= 1'b0;
            done_q    <= 1'b0;
            changed_q <= done_q;
            if (!mouse_right) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (trig_clear) begin
                        state_q      <= S_CLEAR;
                        cnt_q        <= '0;
                        armed_q      <= 1'b0;
                        last_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end else if (trig_stamp) begin
                        state_q      <= S_STAMP;
                        cnt_q        <= '0;
                        last_row_q   <= row;
                        last_col_q   <= col;
                        last_addr_q  <= addr;
                        last_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (!on_canvas) begin
                        last_valid_q <= 1'b0;
                    end
                end
                S_STAMP: begin
                    we_q   <= hit;
                    data_q <= 1'b1;
                    busy_q <= 1'b1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (hit) begin
                        addr_q <= naddr;
                    end
                    if (k == 4'(STAMP_LAST)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    we_q   <= 1'b1;
                    addr_q <= cnt_q;
                    busy_q <= 1'b1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(GRID_CELLS - 1)) begin
                        state_q      <= S_IDLE;
                        last_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign write_enable   = we_q;
    assign write_addr     = addr_q;
    assign write_data     = data_q;
    assign busy           = busy_q;
    assign canvas_changed = changed_q;

endmodule

// File: tb/tb_canvas_painter.sv
// Directed bench for canvas_painter with a cell-level reference model.
// Model schedules expected output beats per edge; a negedge process compares.
module tb_canvas_painter;

    logic       clk = 1'b0;
    logic       rst;
    logic       mouse_left;
    logic       mouse_right;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       write_enable;
    logic [9:0] write_addr;
    logic       write_data;
    logic       busy;
    logic       canvas_changed;

    canvas_painter dut (
        .clk           (clk),
        .rst           (rst),
        .mouse_left    (mouse_left),
        .mouse_right   (mouse_right),
        .mouse_x       (mouse_x),
        .mouse_y       (mouse_y),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .busy          (busy),
        .canvas_changed(canvas_changed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [9:0] addr;
        logic       data;
        logic       busy;
        logic       chg;
    } exp_t;

    localparam exp_t IDLE_E = '{we: 1'b0, addr: 10'd0, data: 1'b0,
                                busy: 1'b0, chg: 1'b0};

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t cur = IDLE_E;
    int   wr_log[$];
    int   chg_count = 0;

    int e2[9] = '{179, 180, 181, 207, 208, 209, 235, 236, 237};
    int e3[4] = '{0, 1, 28, 29};
    int e4[6] = '{0, 1, 2, 28, 29, 30};

    function automatic void chk(string n, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endfunction

    function automatic void push_clear();
        for (int a = 0; a < 784; a++)
            q.push_back('{we: 1'b1, addr: 10'(a), data: 1'b0,
                          busy: 1'b1, chg: 1'b0});
        q.push_back('{we: 1'b0, addr: 10'd0, data: 1'b0,
                      busy: 1'b0, chg: 1'b1});
    endfunction

    function automatic void push_stamp(int r, int c);
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                bit ok = rr >= 0 && rr < 28 && cc >= 0 && cc < 28;
                q.push_back('{we: ok, addr: 10'(ok ? rr * 28 + cc : 0),
                              data: 1'b1, busy: 1'b1, chg: 1'b0});
            end
        q.push_back('{we: 1'b0, addr: 10'd0, data: 1'b0,
                      busy: 1'b0, chg: 1'b1});
    endfunction

    // Reference model: evaluated on every rising edge from the raw inputs
    bit m_armed = 0;
    bit m_lv = 0;
    int m_r = 0;
    int m_c = 0;
    bit rst_pend = 1;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                q.delete();
                rst_pend = 1;
                m_armed = 0;
                m_lv = 0;
            end else begin
                bit idle;
                bit on;
                bit fired;
                int x;
                int y;
                int r;
                int c;
                fired = 0;
                if (rst_pend) begin
                    push_clear();
                    rst_pend = 0;
                end
                idle = q.size() <= 1;
                if (q.size() > 0) cur = q.pop_front();
                else cur = IDLE_E;
                x = int'(mouse_x);
                y = int'(mouse_y);
                on = mouse_left && x >= 208 && x < 432
                     && y >= 128 && y < 352;
                r = (y - 128) / 8;
                c = (x - 208) / 8;
                if (idle) begin
                    if (mouse_right && m_armed) begin
                        cur.busy = 1'b1;
                        push_clear();
                        fired = 1;
                        m_lv = 0;
                    end else if (on && (!m_lv || r != m_r || c != m_c)) begin
                        cur.busy = 1'b1;
                        push_stamp(r, c);
                        m_lv = 1;
                        m_r = r;
                        m_c = c;
                    end else if (!on) begin
                        m_lv = 0;
                    end
                end
                if (!mouse_right) m_armed = 1;
                else if (fired) m_armed = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_we", write_enable, 0);
                chk("rst_addr", write_addr, 0);
                chk("rst_data", write_data, 0);
                chk("rst_busy", busy, 1);
                chk("rst_chg", canvas_changed, 0);
            end else begin
                chk("we", write_enable, cur.we);
                chk("busy", busy, cur.busy);
                chk("changed", canvas_changed, cur.chg);
                if (cur.we) begin
                    chk("addr", write_addr, cur.addr);
                    chk("data", write_data, cur.data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst && write_enable) wr_log.push_back(int'(write_addr));
            if (rst && canvas_changed) chg_count++;
        end
    end

    task automatic wait_changed(input int bound, input string name);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (canvas_changed) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic int log_at(int i);
        return (i < wr_log.size()) ? wr_log[i] : -1;
    endfunction

    initial begin
        rst = 1'b0;
        mouse_left = 1'b0;
        mouse_right = 1'b0;
        mouse_x = 10'd0;
        mouse_y = 10'd0;
        idle_cycles(3);
        rst = 1'b1;

        wait_changed(900, "t1_clear_done");
        chk("t1_beats", wr_log.size(), 784);
        chk("t1_first", log_at(0), 0);
        chk("t1_last", log_at(783), 783);
        chk("t1_busy_after", busy, 0);

        wr_log.delete();
        mouse_x = 10'd308;
        mouse_y = 10'd188;
        mouse_left = 1'b1;
        wait_changed(20, "t2_stamp_done");
        idle_cycles(50);
        chk("t2_beats", wr_log.size(), 9);
        for (int i = 0; i < 9; i++) chk("t2_addr", log_at(i), e2[i]);
        mouse_left = 1'b0;
        idle_cycles(2);

        wr_log.delete();
        mouse_x = 10'd208;
        mouse_y = 10'd128;
        mouse_left = 1'b1;
        wait_changed(20, "t3_stamp_done");
        chk("t3_beats", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_addr", log_at(i), e3[i]);

        wr_log.delete();
        mouse_x = 10'd216;
        wait_changed(20, "t4_stamp_done");
        mouse_x = 10'd219;
        idle_cycles(20);
        chk("t4_beats", wr_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("t4_addr", log_at(i), e4[i]);

        wr_log.delete();
        chg_count = 0;
        mouse_x = 10'd308;
        mouse_right = 1'b1;
        idle_cycles(2);
        mouse_left = 1'b0;
        wait_changed(900, "t5_clear_done");
        idle_cycles(30);
        chk("t5_beats", wr_log.size(), 784);
        chk("t5_changed", chg_count, 1);
        chk("t5_first", log_at(0), 0);
        mouse_right = 1'b0;
        idle_cycles(2);

        wr_log.delete();
        mouse_right = 1'b1;
        @(negedge clk);
        mouse_right = 1'b0;
        for (int i = 0; i < 500 && wr_log.size() < 400; i++) @(negedge clk);
        chk("t6_reached", wr_log.size() >= 400, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_we", write_enable, 0);
        chk("t6_async_busy", busy, 1);
        wr_log.delete();
        idle_cycles(3);
        rst = 1'b1;
        wait_changed(900, "t6_clear_done");
        chk("t6_beats", wr_log.size(), 784);
        chk("t6_restart", log_at(0), 0);
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
